seq_multiplier: RTL
===================

Name: seq_multiplier

Overview:
Parametrised sequential shift-add multiplier. It is the iterative successor to the combinational 4x4 full-adder array multiplier. It computes a WIDTH x WIDTH product using one WIDTH-bit adder reused over WIDTH clock cycles. A start/busy/done handshake lets surrounding logic issue back-to-back multiplies, with optional two's-complement operands.

Parameters:
WIDTH, 4, operand width in bits; legal range 2..32.
SIGNED, 0, 0 = unsigned operands; 1 = two's-complement operands and product.

Ports:
clk  input  1  rising-edge clock; the block's only clock.
rst  input  1  synchronous, active-high reset.
start  input  1  request to begin a multiply; sampled on the rising edge of clk.
A  input  WIDTH  multiplicand; captured only on an accepted start.
B  input  WIDTH  multiplier; captured only on an accepted start.
busy  output  1  high while a multiply is in progress.
done  output  1  single-cycle pulse; Product is valid in the same cycle.
Product  output  2*WIDTH  result; holds its value until the next done.

Behaviour:
- Clocking: one clock (clk). rst is synchronous and active-high; it takes effect only on a clk rising edge.
- Reset values: state=IDLE, busy=0, done=0, Product=0, and all internal registers 0.
- FSM has two states: IDLE and RUN.
- IDLE, start=1 (accepted start):
  - Capture A and B.
  - SIGNED=1: convert each operand to its magnitude and record sign = A[MSB] xor B[MSB].
  - Clear the accumulator and set the iteration counter to 0.
  - Set busy=1 and go to RUN.
- IDLE, start=0: stay in IDLE. Operand input changes are ignored.
- RUN, each cycle:
  - If the multiplier LSB is 1, add the multiplicand to the upper accumulator half. The add is (WIDTH+1)-bit, carry kept.
  - Shift the {carry, accumulator, multiplier} chain right by 1.
  - Increment the counter.
- RUN, last iteration (counter = WIDTH-1):
  - Load Product with the accumulator result; when SIGNED=1 and sign=1, load its two's complement instead.
  - Pulse done=1 for exactly one cycle, clear busy, and return to IDLE.
- Latency: if start is accepted at edge N, done and the new Product appear after edge N+WIDTH. That is exactly WIDTH cycles, independent of operand values (no early termination).
- Throughput:
  - start is accepted in the same cycle that done is high, because the FSM is in IDLE then.
  - Back-to-back issue gives one result every WIDTH+1 cycles.
- start while busy=1: ignored. The in-flight operation and its operands are unaffected, and no queueing occurs.
- rst during RUN: the operation is aborted. No done pulse is generated, Product=0, and the FSM is in IDLE on the next cycle.
- rst and start asserted together: rst wins and the start is not accepted.
- Arithmetic:
  - Unsigned: Product = A*B exactly. The maximum value (2^WIDTH-1)^2 fits in 2*WIDTH bits.
  - Signed:
    - Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1); this is representable because the magnitude register is WIDTH bits, unsigned.
    - The product range [-2^(2W-2)+2^(W-1), 2^(2W-2)] fits in 2*WIDTH bits two's complement.
    - A zero product is never negated to a nonzero value; 0 stays 0.
- Product changes only on the done edge or on rst. It stays stable while busy=1 and while in IDLE.
- done is never high for two consecutive cycles.

Test Plan:
1. WIDTH=4, SIGNED=0. After rst, start with A=3, B=5 at edge 0 -> busy=1 for cycles 1..4, done=1 after edge 4 only, Product=8'h0F. Product stays 8'h0F afterwards.
2. WIDTH=4, SIGNED=0. Exhaustive run of all 256 (A,B) pairs issued back-to-back, with start raised in each done cycle -> every Product equals A*B (e.g. 15x15=8'hE1, 0x9=8'h00), and each result arrives 5 cycles after the previous one.
3. WIDTH=4, SIGNED=1:
   - A=4'hD (-3), B=5 -> 8'hF1.
   - A=4'h8, B=4'h8 (-8 x -8) -> 8'h40.
   - A=4'h8, B=1 -> 8'hF8.
   - A=0, B=4'hF -> 8'h00.
4. Hold start=1 continuously while busy with changing A/B -> first operation completes using the originally captured operands. A new operation is accepted only in the done cycle.
5. Start A=7, B=7, then assert rst for one cycle at cycle 2 of RUN -> no done pulse, Product=0, busy=0. A following start with A=2, B=3 yields 8'h06 after 4 cycles.
6. WIDTH=8, SIGNED=0: A=255, B=255 -> Product=16'hFE01 with done exactly 8 cycles after start. WIDTH=8, SIGNED=1: A=8'h80, B=8'h80 -> 16'h4000.

Source files
------------

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: one (WIDTH+1)-bit adder reused over WIDTH cycles,
// start/busy/done handshake, optional two's-complement operands via sign-magnitude.
module seq_multiplier #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned SIGNED = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   Product
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned PW = 2 * WIDTH;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e             state_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CW-1:0]      cnt_q;
    logic               sign_q;
    logic               busy_q;
    logic               done_q;
    logic [PW-1:0]      product_q;

    logic [WIDTH-1:0]   a_mag_d;
    logic [WIDTH-1:0]   b_mag_d;
    logic               sign_d;
    logic [WIDTH:0]     addend_d;
    logic [WIDTH:0]     sum_d;
    logic [WIDTH-1:0]   acc_d;
    logic [WIDTH-1:0]   mplier_d;
    logic [PW-1:0]      result_d;
    logic [PW-1:0]      product_d;
    logic               last_d;

    // Operand conditioning plus one shift-add step of the {carry, acc, multiplier} chain.
    always_comb begin
        a_mag_d   = A;
        b_mag_d   = B;
        sign_d    = 1'b0;
        if (SIGNED != 0) begin
            if (A[WIDTH-1]) a_mag_d = WIDTH'(-A);
            if (B[WIDTH-1]) b_mag_d = WIDTH'(-B);
            sign_d = A[WIDTH-1] ^ B[WIDTH-1];
        end
        addend_d  = mplier_q[0] ? {1'b0, mcand_q} : '0;
        sum_d     = {1'b0, acc_q} + addend_d;
        acc_d     = sum_d[WIDTH:1];
        mplier_d  = {sum_d[0], mplier_q[WIDTH-1:1]};
        result_d  = {acc_d, mplier_d};
        product_d = result_d;
        // Negating a zero result yields zero, so no special case is needed.
        if ((SIGNED != 0) && sign_q) product_d = PW'(-result_d);
        last_d    = (cnt_q == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            acc_q     <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            sign_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mcand_q  <= a_mag_d;
                        mplier_q <= b_mag_d;
                        sign_q   <= sign_d;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    acc_q    <= acc_d;
                    mplier_q <= mplier_d;
                    cnt_q    <= cnt_q + CW'(1);
                    if (last_d) begin
                        product_q <= product_d;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign Product = product_q;

endmodule
